ajuste_relogio: RTL
===================

Name: ajuste_relogio

Overview:
- Time-setting front end for the clock. It is the input side that writes values into the hour and minute counters, which otherwise only read out time through the BCD display path.
- Debounces two push-buttons (mode, increment).
- Runs an edit FSM over the hour and minute fields, keeping them in BCD.
- Emits a one-cycle load strobe with the new time for the counter chain (seconds forced to 00).
- Clocked on the fast system clock, not the divided 1 Hz clock.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronized samples required before a button level is accepted.
- REPEAT_CYCLES, 25000000: hold time between auto-repeat increments; used only when AUTO_REPEAT_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- btn_mode  in  1  raw mode button, active-high, asynchronous to clk
- btn_inc  in  1  raw increment button, active-high, asynchronous to clk
- cur_h_msd  in  2  current hour tens (BCD)
- cur_h_lsd  in  4  current hour units (BCD)
- cur_m_msd  in  3  current minute tens (BCD)
- cur_m_lsd  in  4  current minute units (BCD)
- set_h_msd  out  2  edited hour tens
- set_h_lsd  out  4  edited hour units
- set_m_msd  out  3  edited minute tens
- set_m_lsd  out  4  edited minute units
- load  out  1  one-cycle strobe: counters take set_* and clear seconds
- editing  out  1  high while in any edit state
- campo  out  2  field under edit: 00 none, 01 hours, 10 minutes

Behaviour:
- Reset and clocking:
  - One clock (clk). Reset rst is synchronous and active-high.
  - On reset: all set_* = 0, load = 0, editing = 0, campo = 00, FSM = RUN, debouncers cleared to "released", repeat counter = 0.
- Debounce (per button):
  - 2-FF synchronizer feeds a stable counter.
  - The counter resets on any change of the synchronized sample.
  - The debounced level updates once the counter reaches DEBOUNCE_CYCLES-1 with the sample unchanged.
  - Press pulse = rising edge of the debounced level, high for one clk.
  - Latency from raw input edge to press pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
- FSM states: RUN, EDIT_H, EDIT_M, COMMIT.
  - RUN: on mode press, go to EDIT_H and capture cur_* into the set_* registers in that same cycle.
  - EDIT_H: on mode press, go to EDIT_M. On inc press, hours += 1 in BCD.
  - EDIT_M: on mode press, go to COMMIT. On inc press, minutes += 1 in BCD.
  - COMMIT: load = 1 for exactly this cycle, then unconditionally go to RUN.
  - editing = 1 in EDIT_H, EDIT_M and COMMIT.
  - campo = 01 in EDIT_H, 10 in EDIT_M, 00 otherwise.
- BCD arithmetic:
  - Hours: lsd 9 -> 0 with msd+1. The value 23 wraps to 00.
  - Minutes: lsd 9 -> 0 with msd+1. The value 59 wraps to 00.
  - Never produces an illegal digit.
  - A captured illegal value (e.g. 24) on the next inc wraps to 00.
- Simultaneous events:
  - Mode press and inc press in the same cycle: mode wins, inc is discarded.
  - Inc presses in RUN or COMMIT are ignored.
- Stability:
  - set_* hold their value outside edit increments.
  - cur_* are sampled only on the RUN->EDIT_H transition.
- Reset mid-edit: returns to RUN with no load pulse; edited values are lost (set_* = 0).

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined:
  - While debounced inc stays high in EDIT_H/EDIT_M, a repeat counter runs.
  - Each time it reaches REPEAT_CYCLES-1 it generates one extra increment and restarts.
  - The counter clears on release, on a mode press, and on leaving the edit states.
- Undefined: exactly one increment per press; no repeat counter is synthesized.

Decomposition:
- Package relogio_pkg:
  - estado_ajuste_t enum {RUN, EDIT_H, EDIT_M, COMMIT}
  - localparams HORA_MAX_MSD=2, HORA_MAX_LSD=3, MIN_MAX_MSD=5, BCD_MAX=9
  - campo encodings CAMPO_NENHUM, CAMPO_HORA, CAMPO_MIN
- Sub-module debounce_botao (synchronizer + stable counter + edge pulse, parameterized by DEBOUNCE_CYCLES), instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8):
1. Reset, then mode press with cur=13:45 -> editing=1, campo=01, set=13:45; no load pulse.
2. Glitch: btn_inc high for 3 cycles in EDIT_H -> no increment. Held for 10 cycles -> exactly one increment, 13 -> 14.
3. Wrap: EDIT_H at 23, one inc -> 00. Then mode to EDIT_M at 59, one inc -> 00. Then mode -> single-cycle load=1 with set=00:00, then editing=0, campo=00.
4. Both debounced presses in the same cycle in EDIT_H at 09 -> state EDIT_M, hours stay 09.
5. rst asserted during EDIT_M -> next cycle state RUN, all outputs 0, no load pulse ever observed.
6. AUTO_REPEAT_EN defined, inc held 30 cycles after debounce in EDIT_M from 10 -> minutes 13 (1 press + 3 repeats). Without the macro -> 11.

Source files
------------

// File: rtl/relogio_pkg.sv
// Shared types, limits and BCD increment helpers for the clock time-setting logic.
package relogio_pkg;

  typedef enum logic [1:0] {RUN, EDIT_H, EDIT_M, COMMIT} estado_ajuste_t;

  localparam logic [1:0] HORA_MAX_MSD = 2'd2;
  localparam logic [3:0] HORA_MAX_LSD = 4'd3;
  localparam logic [2:0] MIN_MAX_MSD  = 3'd5;
  localparam logic [3:0] BCD_MAX      = 4'd9;

  localparam logic [1:0] CAMPO_NENHUM = 2'b00;
  localparam logic [1:0] CAMPO_HORA   = 2'b01;
  localparam logic [1:0] CAMPO_MIN    = 2'b10;

  // Anything at or past 23 (including illegal captured values) wraps to 00.
  function automatic logic [5:0] inc_hora(input logic [1:0] msd, input logic [3:0] lsd);
    if (msd > HORA_MAX_MSD || (msd == HORA_MAX_MSD && lsd >= HORA_MAX_LSD))
      return 6'd0;
    else if (lsd >= BCD_MAX)
      return {msd + 2'd1, 4'd0};
    else
      return {msd, lsd + 4'd1};
  endfunction

  function automatic logic [6:0] inc_min(input logic [2:0] msd, input logic [3:0] lsd);
    if (msd > MIN_MAX_MSD || (msd == MIN_MAX_MSD && lsd >= BCD_MAX))
      return 7'd0;
    else if (lsd >= BCD_MAX)
      return {msd + 3'd1, 4'd0};
    else
      return {msd, lsd + 4'd1};
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and one-cycle press pulse.
module debounce_botao #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic nivel,
  output logic pulso
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2, amostra_ant;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      amostra_ant <= 1'b0;
      cnt         <= '0;
      nivel       <= 1'b0;
      pulso       <= 1'b0;
    end else begin
      sync1       <= btn;
      sync2       <= sync1;
      amostra_ant <= sync2;
      pulso       <= 1'b0;
      if (sync2 != amostra_ant) begin
        cnt <= '0;
      end else if (sync2 != nivel) begin
        if (cnt == CNT_MAX) begin
          cnt   <= '0;
          nivel <= sync2;
          pulso <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ajuste_relogio.sv
// Time-setting front end: debounced mode/inc buttons drive a BCD hour/minute edit FSM
// that emits a one-cycle load strobe. Optional hold-to-repeat via AUTO_REPEAT_EN.
module ajuste_relogio
  import relogio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [1:0] cur_h_msd,
  input  logic [3:0] cur_h_lsd,
  input  logic [2:0] cur_m_msd,
  input  logic [3:0] cur_m_lsd,
  output logic [1:0] set_h_msd,
  output logic [3:0] set_h_lsd,
  output logic [2:0] set_m_msd,
  output logic [3:0] set_m_lsd,
  output logic       load,
  output logic       editing,
  output logic [1:0] campo
);

  estado_ajuste_t estado;
  logic mode_press, inc_press, inc_nivel, mode_nivel_unused;
  logic rep_tick, inc_ev, em_edicao;

  debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_mode),
    .nivel (mode_nivel_unused),
    .pulso (mode_press)
  );

  debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_inc),
    .nivel (inc_nivel),
    .pulso (inc_press)
  );

  assign em_edicao = (estado == EDIT_H) || (estado == EDIT_M);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_ativo;

  assign rep_ativo = em_edicao && inc_nivel && !mode_press;
  assign rep_tick  = rep_ativo && (rep_cnt == REP_MAX);

  always_ff @(posedge clk) begin
    if (rst)
      rep_cnt <= '0;
    else if (rep_ativo)
      rep_cnt <= (rep_cnt == REP_MAX) ? '0 : rep_cnt + 1'b1;
    else
      rep_cnt <= '0;
  end
`else
  localparam int unsigned REPEAT_CYCLES_UNUSED = REPEAT_CYCLES;
  logic inc_nivel_unused;
  assign inc_nivel_unused = inc_nivel;
  assign rep_tick         = 1'b0;
`endif

  assign inc_ev = inc_press || rep_tick;

  // Mode is checked before inc in every edit state, so a simultaneous inc is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= RUN;
      set_h_msd <= '0;
      set_h_lsd <= '0;
      set_m_msd <= '0;
      set_m_lsd <= '0;
      load      <= 1'b0;
      editing   <= 1'b0;
      campo     <= CAMPO_NENHUM;
    end else begin
      load <= 1'b0;
      case (estado)
        RUN: begin
          if (mode_press) begin
            estado    <= EDIT_H;
            set_h_msd <= cur_h_msd;
            set_h_lsd <= cur_h_lsd;
            set_m_msd <= cur_m_msd;
            set_m_lsd <= cur_m_lsd;
            editing   <= 1'b1;
            campo     <= CAMPO_HORA;
          end
        end
        EDIT_H: begin
          if (mode_press) begin
            estado <= EDIT_M;
            campo  <= CAMPO_MIN;
          end else if (inc_ev) begin
            {set_h_msd, set_h_lsd} <= inc_hora(set_h_msd, set_h_lsd);
          end
        end
        EDIT_M: begin
          if (mode_press) begin
            estado <= COMMIT;
            campo  <= CAMPO_NENHUM;
            load   <= 1'b1;
          end else if (inc_ev) begin
            {set_m_msd, set_m_lsd} <= inc_min(set_m_msd, set_m_lsd);
          end
        end
        COMMIT: begin
          estado  <= RUN;
          editing <= 1'b0;
        end
        default: begin
          estado  <= RUN;
          editing <= 1'b0;
          campo   <= CAMPO_NENHUM;
        end
      endcase
    end
  end

endmodule
